// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: boot sequencing, load-use, branch/JALR and memory-wait hazards, EX forwarding.
// Optional perf counters under `ifdef HAZARD_PERF_CNT_EN (perf_stall_cnt / perf_flush_cnt ports).
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              JALRinstrE,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic              pc_en,
  output logic              pc_flush,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

  state_t         state, state_nxt;
  logic [3:0]     boot_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           lw_stall, ctrl, mem, boot_done;

  assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign ctrl      = PCSrcE | JALRinstrE;
  assign mem       = icache_stall | dcache_stall;
  assign boot_done = (boot_cnt == 4'(BOOT_CYCLES - 1));

  // Forwarding is independent of FSM state; M is newer than W so it wins.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     if (boot_done) state_nxt = RUN;
      RUN:      if (mem)       state_nxt = MEM_WAIT;
      MEM_WAIT: if (!mem)      state_nxt = RUN;
      default:                 state_nxt = BOOT;
    endcase
  end

  // RUN and MEM_WAIT share output rules: a redirect held during the freeze
  // is applied in the same cycle memory becomes ready.
  always_comb begin
    pc_en    = 1'b0;
    pc_flush = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    StallW   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem) begin
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          StallW = 1'b1;
        end else if (ctrl) begin
          pc_en  = 1'b1;
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall) begin
          StallD = 1'b1;
          FlushE = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
      default: begin
        pc_flush = 1'b1;
        FlushD   = 1'b1;
        FlushE   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt    <= '0;
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        BOOT:     boot_cnt <= boot_done ? 4'd0 : boot_cnt + 4'd1;
        RUN:      wd_cnt   <= mem ? WDW'(1) : '0;
        MEM_WAIT: begin
          if (!mem)                       wd_cnt <= '0;
          else if (wd_cnt < WDW'(TIMEOUT)) wd_cnt <= wd_cnt + WDW'(1);
          if (mem && (wd_cnt == WDW'(TIMEOUT))) mem_timeout <= 1'b1;
        end
        default:  wd_cnt <= '0;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (state != BOOT) begin
      if (!pc_en) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (FlushD) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (BOOT_CYCLES=2, TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, JALRinstrE;
  logic       icache_stall, dcache_stall;
  logic       pc_en, pc_flush, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // {pc_en, pc_flush, StallD, StallE, StallM, StallW, FlushD, FlushE}
  logic [7:0] ctl;
  assign ctl = {pc_en, pc_flush, StallD, StallE, StallM, StallW, FlushD, FlushE};

  localparam logic [7:0] C_BOOT   = 8'b0100_0011;
  localparam logic [7:0] C_RUN    = 8'b1000_0000;
  localparam logic [7:0] C_LU     = 8'b0010_0001;
  localparam logic [7:0] C_CTRL   = 8'b1000_0011;
  localparam logic [7:0] C_FREEZE = 8'b0011_1100;

  pipeline_hazard_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(8), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .JALRinstrE(JALRinstrE),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_en(pc_en), .pc_flush(pc_flush),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; JALRinstrE = 0;
    icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    total++; if (ctl !== C_BOOT) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_BOOT); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    total++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {ForwardAE, ForwardBE}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (ctl !== C_BOOT) begin bad++; $display("FAIL boot0_ctl got=%b exp=%b", ctl, C_BOOT); end
    @(negedge clk); #1;
    total++; if (ctl !== C_BOOT) begin bad++; $display("FAIL boot1_ctl got=%b exp=%b", ctl, C_BOOT); end
    @(negedge clk); #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL boot_done_ctl got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    idle();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    #1;
    total++; if ({ForwardAE, ForwardBE} !== 4'b1000) begin bad++; $display("FAIL fwd_m_prio got=%b exp=1000", {ForwardAE, ForwardBE}); end
    RegWriteM = 0;
    #1;
    total++; if (ForwardAE !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b exp=01", ForwardAE); end
    RegWriteM = 1; RdM = 9; Rs2E = 9; RegWriteW = 0;
    #1;
    total++; if ({ForwardAE, ForwardBE} !== 4'b0010) begin bad++; $display("FAIL fwd_b_m got=%b exp=0010", {ForwardAE, ForwardBE}); end
    RdM = 0; Rs2E = 0;
    #1;
    total++; if (ForwardBE !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b exp=00", ForwardBE); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_LU); end
    @(negedge clk);
    ResultSrcE0 = 0; RdE = 3;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk);
    ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_ctrl();
    @(negedge clk);
    idle();
    PCSrcE = 1; ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
    #1;
    total++; if (ctl !== C_CTRL) begin bad++; $display("FAIL ctrl_over_lu got=%b exp=%b", ctl, C_CTRL); end
    @(negedge clk);
    idle();
    JALRinstrE = 1;
    #1;
    total++; if (ctl !== C_CTRL) begin bad++; $display("FAIL jalr got=%b exp=%b", ctl, C_CTRL); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle();
    ResultSrcE0 = 1; RdE = 4; Rs1D = 4;
    #1;
    total++; if (ctl !== C_LU) begin bad++; $display("FAIL b2b_lu got=%b exp=%b", ctl, C_LU); end
    @(negedge clk);
    idle();
    PCSrcE = 1;
    #1;
    total++; if (ctl !== C_CTRL) begin bad++; $display("FAIL b2b_br got=%b exp=%b", ctl, C_CTRL); end
  endtask

  task automatic test_mem_branch();
    @(negedge clk);
    idle();
    PCSrcE = 1; dcache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL mem_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
    end
    @(negedge clk);
    dcache_stall = 0;
    #1;
    total++; if (ctl !== C_CTRL) begin bad++; $display("FAIL mem_redirect got=%b exp=%b", ctl, C_CTRL); end
    @(negedge clk);
    idle();
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL mem_back_run got=%b exp=%b", ctl, C_RUN); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL mem_no_timeout got=%b exp=0", mem_timeout); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    idle();
    icache_stall = 1;
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_start got=%b exp=0", mem_timeout); end
    // Eight edges: the transition into MEM_WAIT plus seven more, so wd_cnt==8 now
    repeat (8) @(negedge clk);
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", mem_timeout); end
    total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL to_freeze got=%b exp=%b", ctl, C_FREEZE); end
    @(negedge clk); #1;
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL to_rise got=%b exp=1", mem_timeout); end
    repeat (11) @(negedge clk);
    icache_stall = 0;
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL to_release got=%b exp=%b", ctl, C_RUN); end
    @(negedge clk); #1;
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", mem_timeout); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", mem_timeout); end
    total++; if (ctl !== C_BOOT) begin bad++; $display("FAIL to_reset_ctl got=%b exp=%b", ctl, C_BOOT); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (ctl !== C_RUN) begin bad++; $display("FAIL to_reboot got=%b exp=%b", ctl, C_RUN); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_ctrl();
    test_back_to_back();
    test_mem_branch();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
